// File: rtl/hash_input_loader.sv
// -----------------------------------------------------------------------------
// hash_input_loader
//
// Collects one hash input block of DEPTH bytes from an upstream valid/ready
// byte stream and writes it into ram_a, one byte per accepted transfer. The
// hash controller arms a block with a readin_ok pulse, grants RAM write access
// with the ram_a_we_ok level, and is told the block is complete via full_in.
//
// Handshake: a byte moves on a rising clk edge where set, in_valid and
// in_ready are all 1. in_ready depends only on loader state and ram_a_we_ok,
// never on in_valid. The upstream holds in_data stable while in_valid=1 and
// the byte has not yet been accepted.
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   asynchronous, active-high
//   set           in   global step enable; nothing changes on edges with set=0
//   readin_ok     in   one-cycle pulse that arms (or restarts) a block load
//   ram_a_we_ok   in   level granting write access to ram_a
//   in_valid      in   upstream byte valid
//   in_data       in   upstream byte
//   in_ready      out  loader accepts a byte this cycle (combinational)
//   ram_a_we      out  ram_a write strobe (registered)
//   ram_a_addr    out  ram_a write address (registered)
//   ram_a_din     out  ram_a write data (registered)
//   full_in       out  block complete, held until ram_a_we_ok drops
//   byte_count    out  bytes accepted in the current block, 0..DEPTH
//   overflow_err  out  sticky: a byte was offered while the block was full
//   state_dbg     out  current FSM state (0=IDLE, 1=LOAD, 2=FULL)
// -----------------------------------------------------------------------------
module hash_input_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          readin_ok,
  input  logic          ram_a_we_ok,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          ram_a_we,
  output logic [AW-1:0] ram_a_addr,
  output logic [7:0]    ram_a_din,
  output logic          full_in,
  output logic [AW:0]   byte_count,
  output logic          overflow_err,
  output logic [1:0]    state_dbg
);

  // Encoding is fixed so state_dbg has a stable meaning for observers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE    = {{AW{1'b0}}, 1'b1};

  state_e        state_q;
  logic [AW:0]   byte_count_q;
  logic          ram_a_we_q;
  logic [AW-1:0] ram_a_addr_q;
  logic [7:0]    ram_a_din_q;
  logic          full_in_q;
  logic          overflow_err_q;

  logic          in_ready_d;
  logic          transfer_d;
  logic [AW:0]   count_base_d;
  logic [AW:0]   count_next_d;

  // in_ready is decoded from the state register only, so it is already 0
  // while reset holds the FSM in IDLE.
  assign in_ready_d = (state_q == ST_LOAD) & ram_a_we_ok;
  assign transfer_d = in_valid & in_ready_d;

  // A readin_ok pulse during LOAD restarts the block: the count seen by any
  // same-edge transfer is 0, so that byte lands at address 0.
  always_comb begin
    count_base_d = byte_count_q;
    if (readin_ok) begin
      count_base_d = '0;
    end
  end

  // Saturate at DEPTH; in LOAD the base is always below DEPTH, the guard
  // only makes the no-wrap property explicit.
  always_comb begin
    count_next_d = count_base_d + CNT_ONE;
    if (count_base_d == FULL_COUNT) begin
      count_next_d = FULL_COUNT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      byte_count_q   <= '0;
      ram_a_we_q     <= 1'b0;
      ram_a_addr_q   <= '0;
      ram_a_din_q    <= '0;
      full_in_q      <= 1'b0;
      overflow_err_q <= 1'b0;
    end else if (set) begin
      // Write strobe is a single set-enabled cycle per accepted byte.
      ram_a_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (readin_ok) begin
            state_q      <= ST_LOAD;
            byte_count_q <= '0;
          end
        end

        ST_LOAD: begin
          byte_count_q <= count_base_d;
          if (transfer_d) begin
            ram_a_we_q   <= 1'b1;
            ram_a_addr_q <= count_base_d[AW-1:0];
            ram_a_din_q  <= in_data;
            byte_count_q <= count_next_d;
            // The last byte's write strobe and the first full_in cycle
            // appear together.
            if (count_next_d == FULL_COUNT) begin
              state_q   <= ST_FULL;
              full_in_q <= 1'b1;
            end
          end
        end

        ST_FULL: begin
          // Bytes offered here are dropped and flagged; readin_ok is ignored.
          if (in_valid) begin
            overflow_err_q <= 1'b1;
          end
          if (!ram_a_we_ok) begin
            full_in_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_d;
  assign ram_a_we     = ram_a_we_q;
  assign ram_a_addr   = ram_a_addr_q;
  assign ram_a_din    = ram_a_din_q;
  assign full_in      = full_in_q;
  assign byte_count   = byte_count_q;
  assign overflow_err = overflow_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hash_input_loader.sv
// -----------------------------------------------------------------------------
// tb_hash_input_loader
//
// Drives hash_input_loader with directed scenarios followed by a randomized
// phase. A block-level reference model (phase, bytes accepted so far, flags)
// predicts the loader's visible behaviour; every expected RAM write is
// queued and matched against the DUT's write strobe.
// -----------------------------------------------------------------------------
module tb_hash_input_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset;
  logic          set;
  logic          readin_ok;
  logic          ram_a_we_ok;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          ram_a_we;
  logic [AW-1:0] ram_a_addr;
  logic [7:0]    ram_a_din;
  logic          full_in;
  logic [AW:0]   byte_count;
  logic          overflow_err;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  hash_input_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .set          (set),
    .readin_ok    (readin_ok),
    .ram_a_we_ok  (ram_a_we_ok),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ram_a_we     (ram_a_we),
    .ram_a_addr   (ram_a_addr),
    .ram_a_din    (ram_a_din),
    .full_in      (full_in),
    .byte_count   (byte_count),
    .overflow_err (overflow_err),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [AW+7:0] exp_q[$];   // {addr, data} of each expected RAM write

  // Reference model: 0 = waiting for a block, 1 = filling, 2 = block full
  int            m_phase;
  int            m_cnt;
  bit            m_we;
  bit            m_full;
  bit            m_ovf;
  logic [AW-1:0] last_addr;
  logic [7:0]    last_din;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_cnt     = 0;
    m_we      = 1'b0;
    m_full    = 1'b0;
    m_ovf     = 1'b0;
    last_addr = '0;
    last_din  = '0;
    exp_q.delete();
  endtask

  // Applies the block-loading rules for one rising edge, using the inputs
  // present at that edge.
  task automatic model_edge();
    logic [AW-1:0] a;
    if (!set) return;
    m_we = 1'b0;
    if (m_phase == 0) begin
      if (readin_ok) begin
        m_phase = 1;
        m_cnt   = 0;
      end
    end else if (m_phase == 1) begin
      if (readin_ok) m_cnt = 0;
      if (in_valid && ram_a_we_ok) begin
        a = m_cnt[AW-1:0];
        exp_q.push_back({a, in_data});
        m_we = 1'b1;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_phase = 2;
          m_full  = 1'b1;
        end
      end
    end else begin
      if (in_valid) m_ovf = 1'b1;
      if (!ram_a_we_ok) begin
        m_phase = 0;
        m_full  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input bit edge_en);
    logic [AW+7:0] e;
    check("state", state_dbg, m_phase);
    check("we", ram_a_we, m_we);
    check("full_in", full_in, m_full);
    check("byte_count", byte_count, m_cnt);
    check("overflow_err", overflow_err, m_ovf);
    check("in_ready", in_ready, (m_phase == 1) && ram_a_we_ok);
    if (edge_en && m_we) begin
      if (exp_q.size() == 0) begin
        check("write_queue_empty", 1, 0);
      end else begin
        e         = exp_q.pop_front();
        last_addr = e[AW+7:8];
        last_din  = e[7:0];
      end
    end
    check("addr", ram_a_addr, last_addr);
    check("din", ram_a_din, last_din);
  endtask

  // ---------------------------------------------------------------- driver
  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit s, input bit r, input bit ok, input bit v,
                     input logic [7:0] d);
    set         = s;
    readin_ok   = r;
    ram_a_we_ok = ok;
    in_valid    = v;
    in_data     = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(s);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, ram_a_we, 0);
    check({tag, "_addr"}, ram_a_addr, 0);
    check({tag, "_din"}, ram_a_din, 0);
    check({tag, "_full"}, full_in, 0);
    check({tag, "_cnt"}, byte_count, 0);
    check({tag, "_ovf"}, overflow_err, 0);
    check({tag, "_rdy"}, in_ready, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [AW-1:0] snap_addr;
    logic [7:0]    snap_din;
    logic [AW:0]   snap_cnt;
    logic          snap_we;

    reset       = 1'b1;
    set         = 1'b0;
    readin_ok   = 1'b0;
    ram_a_we_ok = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Nominal load of 0x00..0x1F
    cyc(1, 1, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 1, 8'(i));
    check("nominal_full", full_in, 1);
    check("nominal_cnt", byte_count, DEPTH);
    check("nominal_last_addr", ram_a_addr, DEPTH - 1);

    // Overflow while full, and readin_ok ignored
    cyc(1, 0, 1, 1, 8'hAA);
    cyc(1, 1, 1, 1, 8'h55);
    check("overflow_set", overflow_err, 1);
    check("overflow_no_we", ram_a_we, 0);
    check("overflow_still_full", full_in, 1);
    cyc(1, 0, 1, 0, 8'h00);
    check("overflow_sticky", overflow_err, 1);

    // Release
    cyc(1, 0, 0, 0, 8'h00);
    check("release_full", full_in, 0);
    check("release_state", state_dbg, 0);
    check("release_rdy", in_ready, 0);

    // Stall after 10 bytes
    cyc(1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 8'hC3);
    check("stall_cnt", byte_count, 10);
    cyc(1, 0, 1, 1, 8'hC3);
    check("resume_addr", ram_a_addr, 10);
    check("resume_din", ram_a_din, 8'hC3);

    // Restart mid-block at count 7 with a same-edge byte
    cyc(1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, 1, 8'($urandom_range(0, 255)));
    cyc(1, 1, 1, 1, 8'h7E);
    check("restart_addr", ram_a_addr, 0);
    check("restart_cnt", byte_count, 1);
    check("restart_we", ram_a_we, 1);

    // set=0 freezes everything, including the write strobe
    snap_addr = ram_a_addr;
    snap_din  = ram_a_din;
    snap_cnt  = byte_count;
    snap_we   = ram_a_we;
    for (int i = 0; i < 3; i++)
      cyc(0, 1'($urandom_range(0, 1)), 1, 1, 8'($urandom_range(0, 255)));
    check("freeze_addr", ram_a_addr, snap_addr);
    check("freeze_din", ram_a_din, snap_din);
    check("freeze_cnt", byte_count, snap_cnt);
    check("freeze_we", ram_a_we, snap_we);

    // Asynchronous reset at byte 15 of a fresh block
    cyc(1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 15; i++) cyc(1, 0, 1, 1, 8'($urandom_range(0, 255)));
    cyc(1, 0, 1, 1, 8'h99);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 8'($urandom_range(0, 255)));
    check("post_reset_cnt", byte_count, 0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) != 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 9) < 7),
          8'($urandom_range(0, 255)));
    end

    check("writes_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_input_loader.md
HASH_INPUT_LOADER -- requirements
Module: hash_input_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning bytes per hash input block (ram_a size).
REQ-002 SHALL have parameter AW, default 5, meaning ram_a address width; DEPTH = 2**AW.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port set  in  1  global step enable; registers update only on clk edges with set=1.
REQ-006 SHALL have port readin_ok  in  1  one-cycle pulse from the hash controller that arms a new block load.
REQ-007 SHALL have port ram_a_we_ok  in  1  level from the hash controller granting write access to ram_a.
REQ-008 SHALL have port in_valid  in  1  upstream byte valid.
REQ-009 SHALL have port in_data  in  8  upstream byte.
REQ-010 SHALL have port in_ready  out  1  loader accepts a byte this cycle.
REQ-011 SHALL have port ram_a_we  out  1  ram_a write strobe, registered.
REQ-012 SHALL have port ram_a_addr  out  AW  ram_a write address, registered.
REQ-013 SHALL have port ram_a_din  out  8  ram_a write data, registered.
REQ-014 SHALL have port full_in  out  1  block complete; level to the hash controller.
REQ-015 SHALL have port byte_count  out  AW+1  bytes accepted in the current block, 0..DEPTH.
REQ-016 SHALL have port overflow_err  out  1  sticky error: byte offered while block full.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, FULL; all transitions on clk edges with set=1.
REQ-018 SHALL, in IDLE, go to LOAD and clear byte_count when readin_ok=1; otherwise stay in IDLE.
REQ-019 SHALL drive in_ready = (state==LOAD) & ram_a_we_ok, combinationally.
REQ-020 SHALL count a transfer only on an edge where set & in_valid & in_ready are all 1.
REQ-021 SHALL, on a transfer, register ram_a_we=1, ram_a_addr=byte_count[AW-1:0], ram_a_din=in_data, and increment byte_count; write latency is 1 cycle.
REQ-022 SHALL clear ram_a_we on the next set-enabled edge with no transfer; no write strobe lasts more than one set-enabled cycle per byte.
REQ-023 SHALL stall with no write and no count change in LOAD when ram_a_we_ok=0.
REQ-024 SHALL go from LOAD to FULL and register full_in=1 on the transfer that makes byte_count==DEPTH; the last byte's ram_a_we pulse coincides with the first full_in=1 cycle.
REQ-025 SHALL hold full_in=1 in FULL until ram_a_we_ok is sampled 0, then clear full_in and go to IDLE on that edge.
REQ-026 SHALL, in FULL, set overflow_err=1 when in_valid=1, drop the byte, and make no RAM write.
REQ-027 SHALL, on readin_ok=1 in LOAD (restart mid-block), clear byte_count to 0 and stay in LOAD; any transfer on the same edge is written to address 0 and byte_count becomes 1.
REQ-028 SHALL ignore readin_ok in FULL.
REQ-029 SHALL hold every register, including ram_a_we, when set=0.
REQ-030 SHALL keep byte_count saturating at DEPTH; it never wraps.

Reset
REQ-031 SHALL, while reset=1, asynchronously force state=IDLE and byte_count=0, and drive ram_a_we, ram_a_addr, ram_a_din, full_in, overflow_err and in_ready to 0.
REQ-032 SHALL abandon a partial block when reset is asserted mid-LOAD, with no further ram_a_we pulses after reset deasserts until a new readin_ok.
REQ-033 SHALL clear overflow_err only by reset.

Verification
REQ-034 SHALL verify a nominal load: readin_ok pulse, ram_a_we_ok=1, 32 consecutive bytes 0x00..0x1F -> 32 writes addr n/data n, full_in=1 one cycle after the 32nd handshake, byte_count=32.
REQ-035 SHALL verify release: in FULL, drop ram_a_we_ok -> full_in=0 next edge, state IDLE, in_ready=0.
REQ-036 SHALL verify stall: ram_a_we_ok=0 after byte 10 for 5 cycles with in_valid=1 -> no writes, byte_count stays 10; resume -> byte 10 written to addr 10.
REQ-037 SHALL verify overflow: in_valid=1 in FULL -> overflow_err=1 and sticky, no ram_a_we pulse.
REQ-038 SHALL verify restart and set gating: readin_ok at byte_count=7 -> next byte goes to addr 0; with set=0 for 3 cycles -> all outputs frozen.
REQ-039 SHALL verify async reset mid-LOAD at byte 15 -> outputs 0 immediately; after deassert, no writes until readin_ok.
